// File: rtl/mem_write_buffer_pkg.sv
// Shared definitions for the posted-write buffer: arbiter states and
// the memory-port transaction-type encoding.
package mem_write_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WR_BUSY = 2'b01,
        RD_BUSY = 2'b10
    } wb_state_e;

    localparam logic MEM_OP_WRITE = 1'b1;
    localparam logic MEM_OP_READ  = 1'b0;

endpackage

// File: rtl/mem_write_buffer_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap naturally
// because DEPTH is a power of two. Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the data cache and main memory: queues
// write-through stores and arbitrates them with line-fill reads, writes first.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_rdy,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [$clog2(DEPTH):0]    wb_count
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    wb_state_e               state_r;
    wb_state_e               state_nxt_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    push_s;
    logic                    pop_s;
    logic [ENTRY_W-1:0]      head_s;
    logic [ADDR_WIDTH-1:0]   head_addr_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic                    mem_req_nxt_s;
    logic                    mem_we_nxt_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_nxt_s;

    assign wr_rdy                     = !fifo_full_s;
    assign push_s                     = wr_en && wr_rdy;
    assign pop_s                      = (state_r == WR_BUSY) && mem_ack;
    assign {head_addr_s, head_data_s} = head_s;
    assign rd_valid                   = (state_r == RD_BUSY) && mem_ack;
    assign rd_data                    = mem_rdata;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({wr_addr, wr_data}),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (wb_count)
    );

    // State and memory-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
            mem_wdata <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            mem_req   <= mem_req_nxt_s;
            mem_we    <= mem_we_nxt_s;
            mem_addr  <= mem_addr_nxt_s;
            mem_wdata <= mem_wdata_nxt_s;
        end
    end

    // Next-state: buffered writes always win over a pending line fill.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = WR_BUSY;
                end else if (rd_en) begin
                    state_nxt_s = RD_BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_BUSY, RD_BUSY: begin
                if (mem_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory-port values to register; held steady while a request is outstanding.
    always_comb begin
        mem_req_nxt_s   = mem_req;
        mem_we_nxt_s    = mem_we;
        mem_addr_nxt_s  = mem_addr;
        mem_wdata_nxt_s = mem_wdata;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = MEM_OP_WRITE;
                    mem_addr_nxt_s  = head_addr_s;
                    mem_wdata_nxt_s = head_data_s;
                end else if (rd_en) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = MEM_OP_READ;
                    mem_addr_nxt_s  = rd_addr;
                end else begin
                    mem_req_nxt_s   = 1'b0;
                end
            end
            WR_BUSY, RD_BUSY: begin
                if (mem_ack) begin
                    mem_req_nxt_s = 1'b0;
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            default: mem_req_nxt_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: directed scenarios plus randomized
// rounds scored against a transaction-level model of the memory-port order.
module tb_mem_write_buffer;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_rdy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    wb_count;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          obs_q[$];
    int            pass_cnt  = 0;
    int            chk_cnt   = 0;
    int            rdv_cnt   = 0;
    int            stab_err  = 0;
    int            wr_done   = 0;
    logic [DW-1:0] last_rd   = 32'h0;
    logic [AW+DW:0] held     = '0;
    logic          held_v    = 1'b0;
    bit            ack_en    = 1'b0;
    int            ack_delay = 1;
    logic [DW-1:0] rd_resp   = 32'h0;

    mem_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Memory model: acks ack_delay cycles after the request is seen, changes 1 time unit after posedge.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req || mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (ack_en) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_resp;
                end
            end
        end
    end

    // Transaction recorder and request-stability monitor.
    always @(posedge clk) begin
        if (!rst && mem_req) begin
            if (held_v && ({mem_we, mem_addr, mem_wdata} !== held)) stab_err <= stab_err + 1;
            held   <= {mem_we, mem_addr, mem_wdata};
            held_v <= !mem_ack;
            if (mem_ack) begin
                obs_q.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : mem_rdata)});
                if (mem_we) wr_done <= wr_done + 1;
            end
        end else begin
            held_v <= 1'b0;
        end
        if (!rst && rd_valid) begin
            rdv_cnt <= rdv_cnt + 1;
            last_rd <= rd_data;
        end
    end

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = 16'h0; wr_data = 32'h0; rd_addr = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (wr_rdy !== 1'b1) $display("FAIL reset_wr_rdy got %b want 1", wr_rdy); else pass_cnt++;
        chk_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else pass_cnt++;
        chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else pass_cnt++;
        chk_cnt++; if (wb_count !== 3'd0) $display("FAIL reset_wb_count got %0d want 0", wb_count); else pass_cnt++;
        chk_cnt++; if ({mem_we, mem_addr, mem_wdata} !== 49'h0)
            $display("FAIL reset_mem_port got we=%b addr=%h data=%h want 0", mem_we, mem_addr, mem_wdata); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        int base; int stab0; int cyc;
        base = obs_q.size(); stab0 = stab_err; ack_en = 1'b1; ack_delay = 3;
        @(negedge clk); wr_en = 1'b1; wr_addr = 16'h0010; wr_data = 32'hDEADBEEF;
        @(negedge clk); wr_en = 1'b0;
        chk_cnt++; if (wb_count !== 3'd1) $display("FAIL single_count_push got %0d want 1", wb_count); else pass_cnt++;
        chk_cnt++; if (mem_req !== 1'b0) $display("FAIL single_req_latency got %b want 0", mem_req); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0010, 32'hDEADBEEF})
            $display("FAIL single_issue got req=%b we=%b addr=%h data=%h want 1 1 0010 deadbeef",
                     mem_req, mem_we, mem_addr, mem_wdata); else pass_cnt++;
        cyc = 0;
        while (wb_count !== 3'd0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk_cnt++; if (cyc != 3) $display("FAIL single_ack_cycles got %0d want 3", cyc); else pass_cnt++;
        chk_cnt++; if (mem_req !== 1'b0) $display("FAIL single_req_drop got %b want 0", mem_req); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != base + 1) $display("FAIL single_txn_count got %0d want %0d", obs_q.size(), base + 1); else pass_cnt++;
        if (obs_q.size() > base) begin
            chk_cnt++; if (obs_q[base] !== {1'b1, 16'h0010, 32'hDEADBEEF})
                $display("FAIL single_txn got %h want 10010deadbeef", obs_q[base]); else pass_cnt++;
        end
        chk_cnt++; if (stab_err != stab0) $display("FAIL single_stable got %0d want %0d", stab_err, stab0); else pass_cnt++;
    endtask

    task automatic test_full();
        int base; int cyc;
        base = obs_q.size(); ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_cnt++; if (wr_rdy !== (i < DEPTH)) $display("FAIL full_wr_rdy_%0d got %b want %b", i, wr_rdy, (i < DEPTH)); else pass_cnt++;
            wr_en = 1'b1; wr_addr = 16'(i); wr_data = 32'hA5A50000 + 32'(i);
        end
        @(negedge clk); wr_en = 1'b0;
        chk_cnt++; if (wb_count !== 3'd4) $display("FAIL full_count got %0d want 4", wb_count); else pass_cnt++;
        chk_cnt++; if (wr_rdy !== 1'b0) $display("FAIL full_wr_rdy got %b want 0", wr_rdy); else pass_cnt++;
        chk_cnt++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000})
            $display("FAIL full_head_issue got req=%b addr=%h want 1 0000", mem_req, mem_addr); else pass_cnt++;
        ack_en = 1'b1; ack_delay = 1; cyc = 0;
        while (!(wb_count === 3'd0 && mem_req === 1'b0) && cyc < 60) begin @(negedge clk); cyc++; end
        chk_cnt++; if (cyc >= 60) $display("FAIL full_drain_timeout got %0d cycles want <60", cyc); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != base + 4) $display("FAIL full_txn_count got %0d want %0d", obs_q.size(), base + 4); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (obs_q.size() > base + i) begin
                chk_cnt++; if (obs_q[base + i] !== {1'b1, 16'(i), 32'hA5A50000 + 32'(i)})
                    $display("FAIL full_order_%0d got %h want addr %0d", i, obs_q[base + i], i); else pass_cnt++;
            end
        end
    endtask

    task automatic test_drain_before_read();
        int base; int rdv0; int cyc; txn_t exp_t[3];
        base = obs_q.size(); rdv0 = rdv_cnt; ack_en = 1'b0; rd_resp = 32'h12345678;
        exp_t[0] = {1'b1, 16'h0100, 32'h11110000};
        exp_t[1] = {1'b1, 16'h0101, 32'h22220000};
        exp_t[2] = {1'b0, 16'h0040, 32'h12345678};
        @(negedge clk); wr_en = 1'b1; wr_addr = 16'h0100; wr_data = 32'h11110000;
        @(negedge clk); wr_addr = 16'h0101; wr_data = 32'h22220000;
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b1; rd_addr = 16'h0040;
        chk_cnt++; if (wb_count !== 3'd2) $display("FAIL drain_pending got %0d want 2", wb_count); else pass_cnt++;
        ack_en = 1'b1; ack_delay = 2; cyc = 0;
        while (rdv_cnt == rdv0 && cyc < 80) begin @(negedge clk); cyc++; end
        rd_en = 1'b0;
        chk_cnt++; if (cyc >= 80) $display("FAIL drain_read_timeout got %0d cycles want <80", cyc); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (rdv_cnt != rdv0 + 1) $display("FAIL drain_rd_valid_pulses got %0d want 1", rdv_cnt - rdv0); else pass_cnt++;
        chk_cnt++; if (last_rd !== 32'h12345678) $display("FAIL drain_rd_data got %h want 12345678", last_rd); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != base + 3) $display("FAIL drain_txn_count got %0d want %0d", obs_q.size(), base + 3); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (obs_q.size() > base + i) begin
                chk_cnt++; if (obs_q[base + i] !== exp_t[i])
                    $display("FAIL drain_order_%0d got %h want %h", i, obs_q[base + i], exp_t[i]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap_simultaneous();
        int base; int cyc; txn_t exp_q[$];
        base = obs_q.size(); ack_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk_cnt++; if (wb_count !== 3'd3) $display("FAIL wrap_count_pre got %0d want 3", wb_count); else pass_cnt++;
            end
            if (k == 4) begin
                chk_cnt++; if (wb_count !== 3'd3) $display("FAIL wrap_count_push_pop got %0d want 3", wb_count); else pass_cnt++;
                chk_cnt++; if (obs_q.size() != base + 1) $display("FAIL wrap_pop_seen got %0d want 1", obs_q.size() - base); else pass_cnt++;
            end
            cyc = 0;
            while (wr_rdy !== 1'b1 && cyc < 20) begin wr_en = 1'b0; @(negedge clk); cyc++; end
            wr_en = 1'b1; wr_addr = 16'($urandom_range(0, 65535)); wr_data = $urandom;
            exp_q.push_back({1'b1, wr_addr, wr_data});
            if (k == 2) begin ack_en = 1'b1; ack_delay = 1; end
        end
        @(negedge clk); wr_en = 1'b0; cyc = 0;
        while (!(wb_count === 3'd0 && mem_req === 1'b0) && cyc < 60) begin @(negedge clk); cyc++; end
        chk_cnt++; if (obs_q.size() != base + 6) $display("FAIL wrap_txn_count got %0d want %0d", obs_q.size(), base + 6); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (obs_q.size() > base + i) begin
                chk_cnt++; if (obs_q[base + i] !== exp_q[i])
                    $display("FAIL wrap_order_%0d got %h want %h", i, obs_q[base + i], exp_q[i]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int base;
        ack_en = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_addr = 16'h0200; wr_data = 32'hCAFE0001;
        @(negedge clk); wr_addr = 16'h0201; wr_data = 32'hCAFE0002;
        @(negedge clk); wr_en = 1'b0;
        chk_cnt++; if ({mem_req, wb_count} !== {1'b1, 3'd2})
            $display("FAIL midrst_pre got req=%b count=%0d want 1 2", mem_req, wb_count); else pass_cnt++;
        base = obs_q.size();
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if (mem_req !== 1'b0) $display("FAIL midrst_req got %b want 0", mem_req); else pass_cnt++;
        chk_cnt++; if (wb_count !== 3'd0) $display("FAIL midrst_count got %0d want 0", wb_count); else pass_cnt++;
        chk_cnt++; if (wr_rdy !== 1'b1) $display("FAIL midrst_wr_rdy got %b want 1", wr_rdy); else pass_cnt++;
        rst = 1'b0; ack_en = 1'b1;
        repeat (4) @(negedge clk);
        chk_cnt++; if (mem_req !== 1'b0 || obs_q.size() != base)
            $display("FAIL midrst_discard got req=%b txns=%0d want 0 0", mem_req, obs_q.size() - base); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int base; int pushed; int done0; int model_cnt; int rdv0; int cyc; txn_t exp_q[$];
            base = obs_q.size(); pushed = 0; done0 = wr_done; ack_en = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                ack_delay = $urandom_range(1, 3);
                model_cnt = pushed - (wr_done - done0);
                chk_cnt++; if (wr_rdy !== (model_cnt != DEPTH))
                    $display("FAIL rand_wr_rdy r%0d c%0d got %b want %b", r, c, wr_rdy, (model_cnt != DEPTH)); else pass_cnt++;
                chk_cnt++; if (wb_count !== 3'(model_cnt))
                    $display("FAIL rand_count r%0d c%0d got %0d want %0d", r, c, wb_count, model_cnt); else pass_cnt++;
                wr_en = 1'($urandom_range(0, 1)); wr_addr = 16'($urandom_range(0, 65535)); wr_data = $urandom;
                if (wr_en && model_cnt != DEPTH) begin
                    exp_q.push_back({1'b1, wr_addr, wr_data});
                    pushed++;
                end
            end
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b1; rd_addr = 16'($urandom_range(0, 65535)); rd_resp = $urandom;
            exp_q.push_back({1'b0, rd_addr, rd_resp});
            rdv0 = rdv_cnt; cyc = 0;
            while (rdv_cnt == rdv0 && cyc < 200) begin @(negedge clk); cyc++; end
            rd_en = 1'b0;
            @(negedge clk);
            chk_cnt++; if (last_rd !== rd_resp) $display("FAIL rand_rd_data r%0d got %h want %h", r, last_rd, rd_resp); else pass_cnt++;
            chk_cnt++; if (obs_q.size() != base + exp_q.size())
                $display("FAIL rand_txn_count r%0d got %0d want %0d", r, obs_q.size() - base, exp_q.size()); else pass_cnt++;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (obs_q.size() > base + i) begin
                    chk_cnt++; if (obs_q[base + i] !== exp_q[i])
                        $display("FAIL rand_order r%0d i%0d got %h want %h", r, i, obs_q[base + i], exp_q[i]); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (stab_err != 0) $display("FAIL req_stability got %0d violations want 0", stab_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full();
        test_drain_before_read();
        test_wrap_simultaneous();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
